// File: rtl/prim_lutram_sdp.sv
// Simple dual-port distributed RAM: one synchronous write port, one
// asynchronous (combinational) read port. Contents are not reset.
//   clk    : write clock
//   wen    : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module prim_lutram_sdp #(
  parameter int N_ENTRIES   = 2,
  parameter int N_DATA_BITS = 32
) (
  input  logic                         clk,
  input  logic                         wen,
  input  logic [$clog2(N_ENTRIES)-1:0] waddr,
  input  logic [N_DATA_BITS-1:0]       wdata,
  input  logic [$clog2(N_ENTRIES)-1:0] raddr,
  output logic [N_DATA_BITS-1:0]       rdata
);
  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/prim_fifo_lutram.sv
// First-word-fall-through FIFO on distributed RAM, with an optional
// one-entry output register to cut the RAM read path to `first`.
//   clk, reset  : clock, asynchronous active-high reset
//   enq_data    : entry to enqueue
//   enq_en      : enqueue this cycle (ignored while notFull=0)
//   notFull     : RAM has at least one free slot
//   almostFull  : free RAM slots <= THRESHOLD
//   first       : head entry, valid while notEmpty=1
//   deq_en      : consume the head entry this cycle
//   notEmpty    : head entry valid
module prim_fifo_lutram #(
  parameter int N_DATA_BITS     = 32,
  parameter int N_ENTRIES       = 2,
  parameter int THRESHOLD       = 1,
  parameter int REGISTER_OUTPUT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic                   enq_en,
  output logic                   notFull,
  output logic                   almostFull,
  output logic [N_DATA_BITS-1:0] first,
  input  logic                   deq_en,
  output logic                   notEmpty
);
  localparam int AW = $clog2(N_ENTRIES);
  localparam int CW = AW + 1;

  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic [N_DATA_BITS-1:0] rdata;
  logic                   do_enq, lut_rd, lut_has;

  // Flags come only from registered count, so enq/deq never feed them combinationally.
  assign notFull    = (count != CW'(N_ENTRIES));
  assign almostFull = ((CW'(N_ENTRIES) - count) <= CW'(THRESHOLD));
  assign lut_has    = (count != '0);
  assign do_enq     = enq_en && notFull;

  prim_lutram_sdp #(
    .N_ENTRIES  (N_ENTRIES),
    .N_DATA_BITS(N_DATA_BITS)
  ) u_ram (
    .clk  (clk),
    .wen  (do_enq),
    .waddr(wr_ptr),
    .wdata(enq_data),
    .raddr(rd_ptr),
    .rdata(rdata)
  );

  generate
    if (REGISTER_OUTPUT != 0) begin : g_oreg
      logic                   out_vld;
      logic [N_DATA_BITS-1:0] out_data;
      // Refill whenever the register is empty or being consumed; that read frees a RAM slot.
      assign lut_rd = (!out_vld || deq_en) && lut_has;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          out_vld  <= 1'b0;
          out_data <= '0;
        end else if (lut_rd) begin
          out_vld  <= 1'b1;
          out_data <= rdata;
        end else if (deq_en) begin
          out_vld  <= 1'b0;
        end
      end

      assign first    = out_data;
      assign notEmpty = out_vld;
    end else begin : g_noreg
      assign lut_rd   = deq_en && lut_has;
      assign first    = rdata;
      assign notEmpty = lut_has;
    end
  endgenerate

  // Pointers wrap naturally since N_ENTRIES is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (lut_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_enq) - CW'(lut_rd);
    end
  end

`ifndef SYNTHESIS
  // Protocol checks: misuse is reported but the hardware simply drops/ignores it.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(enq_en && !notFull))
        else $warning("prim_fifo_lutram: enq_en while full, entry dropped");
      assert (!(deq_en && !notEmpty))
        else $warning("prim_fifo_lutram: deq_en while empty, ignored");
    end
  end
`endif
endmodule

// File: tb/tb_prim_fifo_lutram.sv
module tb_prim_fifo_lutram;
  localparam int W  = 16;
  localparam int N  = 8;
  localparam int TH = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0] enq_data0, first0, enq_data1, first1;
  logic enq_en0, deq_en0, nf0, af0, ne0;
  logic enq_en1, deq_en1, nf1, af1, ne1;

  prim_fifo_lutram #(.N_DATA_BITS(W), .N_ENTRIES(N), .THRESHOLD(TH), .REGISTER_OUTPUT(0)) u_dut0 (
    .clk(clk), .reset(reset), .enq_data(enq_data0), .enq_en(enq_en0), .notFull(nf0),
    .almostFull(af0), .first(first0), .deq_en(deq_en0), .notEmpty(ne0));

  prim_fifo_lutram #(.N_DATA_BITS(W), .N_ENTRIES(N), .THRESHOLD(TH), .REGISTER_OUTPUT(1)) u_dut1 (
    .clk(clk), .reset(reset), .enq_data(enq_data1), .enq_en(enq_en1), .notFull(nf1),
    .almostFull(af1), .first(first1), .deq_en(deq_en1), .notEmpty(ne1));

  int n_chk = 0, n_err = 0;

  // Reference: dut0 is just a bounded queue; dut1 is a bounded queue feeding a one-slot holder.
  int q0[$];
  int lq1[$];
  bit ov1;
  int od1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("nf0", 32'(nf0), 32'(q0.size() < N));
    chk("af0", 32'(af0), 32'((N - q0.size()) <= TH));
    chk("ne0", 32'(ne0), 32'(q0.size() > 0));
    if (q0.size() > 0) chk("first0", 32'(first0), 32'(q0[0]));
    chk("nf1", 32'(nf1), 32'(lq1.size() < N));
    chk("af1", 32'(af1), 32'((N - lq1.size()) <= TH));
    chk("ne1", 32'(ne1), 32'(ov1));
    if (ov1) chk("first1", 32'(first1), 32'(od1));
  endtask

  task automatic idle();
    enq_en0 = 0; deq_en0 = 0; enq_en1 = 0; deq_en1 = 0;
  endtask

  // One clock: apply model to the inputs seen at the edge, then check and clear inputs.
  task automatic step();
    bit acc, dq, ld;
    @(posedge clk);
    if (!reset) begin
      acc = enq_en0 && (q0.size() < N);
      dq  = deq_en0 && (q0.size() > 0);
      if (dq) void'(q0.pop_front());
      if (acc) q0.push_back(int'(enq_data0));
      acc = enq_en1 && (lq1.size() < N);
      ld  = (!ov1 || deq_en1) && (lq1.size() > 0);
      if (ld) begin od1 = lq1.pop_front(); ov1 = 1; end
      else if (deq_en1 && ov1) ov1 = 0;
      if (acc) lq1.push_back(int'(enq_data1));
    end
    #1;
    check_model();
    idle();
  endtask

  initial begin
    idle();
    enq_data0 = '0; enq_data1 = '0;
    ov1 = 0; od1 = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_nf0", 32'(nf0), 1); chk("rst_ne0", 32'(ne0), 0); chk("rst_af0", 32'(af0), 0);
    chk("rst_nf1", 32'(nf1), 1); chk("rst_ne1", 32'(ne1), 0); chk("rst_af1", 32'(af1), 0);
    reset = 1'b0;

    // First entry visible one edge later (dut0), two edges later (dut1)
    enq_en0 = 1; enq_data0 = 16'h1234; enq_en1 = 1; enq_data1 = 16'h1234;
    step();
    chk("fwft_ne0", 32'(ne0), 1); chk("fwft_first0", 32'(first0), 32'h1234);
    chk("reg_ne1_k", 32'(ne1), 0);
    step();
    chk("reg_ne1_k1", 32'(ne1), 1); chk("reg_first1", 32'(first1), 32'h1234);
    deq_en0 = 1; deq_en1 = 1; step();
    chk("drain_ne0", 32'(ne0), 0); chk("drain_ne1", 32'(ne1), 0);

    // Fill dut0 with 0..7
    for (int i = 0; i < N; i++) begin
      enq_en0 = 1; enq_data0 = W'(i); step();
      if (i == 4) chk("af_after5", 32'(af0), 0);
      if (i == 5) chk("af_after6", 32'(af0), 1);
      if (i == 6) chk("nf_after7", 32'(nf0), 1);
      if (i == 7) chk("nf_after8", 32'(nf0), 0);
    end
    enq_en0 = 1; enq_data0 = 16'h0099; step();
    chk("drop9_nf", 32'(nf0), 0); chk("drop9_head", 32'(first0), 0);
    // Full: enq+deq together, enqueue must be dropped
    enq_en0 = 1; enq_data0 = 16'h00A5; deq_en0 = 1; step();
    chk("fullsim_nf", 32'(nf0), 1); chk("fullsim_head", 32'(first0), 1);
    for (int i = 1; i < N; i++) begin
      chk("order", 32'(first0), 32'(i));
      deq_en0 = 1; step();
    end
    chk("empty_after", 32'(ne0), 0);

    // Wrap-around with steady occupancy of one
    enq_en0 = 1; enq_data0 = 16'd100; step();
    for (int i = 0; i < 20; i++) begin
      enq_en0 = 1; enq_data0 = W'(101 + i); deq_en0 = 1; step();
      chk("wrap_first", 32'(first0), 32'(101 + i));
      chk("wrap_ne", 32'(ne0), 1);
    end
    deq_en0 = 1; step();

    // Registered output: latency and N+1 capacity
    enq_en1 = 1; enq_data1 = 16'h0055; step();
    chk("r55_k", 32'(ne1), 0);
    step();
    chk("r55_k1", 32'(ne1), 1); chk("r55_first", 32'(first1), 32'h55);
    for (int i = 1; i <= N; i++) begin
      enq_en1 = 1; enq_data1 = W'(i); step();
    end
    chk("r_full", 32'(nf1), 0);
    enq_en1 = 1; enq_data1 = 16'h00EE; step();
    chk("r_drop_nf", 32'(nf1), 0);
    for (int i = 0; i <= N; i++) begin
      chk("r_order", 32'(first1), (i == 0) ? 32'h55 : 32'(i));
      chk("r_ne", 32'(ne1), 1);
      deq_en1 = 1; step();
    end
    chk("r_empty", 32'(ne1), 0);

    // Random traffic against the reference
    for (int c = 0; c < 800; c++) begin
      enq_en0 = ($urandom_range(0, 99) < 55); enq_data0 = W'($urandom);
      deq_en0 = ne0 && ($urandom_range(0, 99) < 45);
      enq_en1 = ($urandom_range(0, 99) < 50); enq_data1 = W'($urandom);
      deq_en1 = ne1 && ($urandom_range(0, 99) < 50);
      step();
    end

    // Reset mid-stream
    while (q0.size() > 0 || ov1) begin
      deq_en0 = ne0; deq_en1 = ne1; step();
      if (n_chk > 60000) break;
    end
    for (int i = 0; i < 5; i++) begin
      enq_en0 = 1; enq_data0 = W'(16'h40 + i); enq_en1 = 1; enq_data1 = W'(16'h40 + i); step();
    end
    chk("pre_rst_ne0", 32'(ne0), 1);
    reset = 1'b1;
    #1;
    chk("mrst_ne0", 32'(ne0), 0); chk("mrst_nf0", 32'(nf0), 1);
    chk("mrst_ne1", 32'(ne1), 0); chk("mrst_nf1", 32'(nf1), 1);
    q0.delete(); lq1.delete(); ov1 = 0;
    step();
    reset = 1'b0;
    enq_en0 = 1; enq_data0 = 16'h0077; enq_en1 = 1; enq_data1 = 16'h0077; step();
    chk("post_rst_first0", 32'(first0), 32'h77);
    step();
    chk("post_rst_first1", 32'(first1), 32'h77);
    deq_en0 = 1; deq_en1 = 1; step();
    chk("post_rst_ne0", 32'(ne0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
